// File: rtl/qeciphy_rx_ctrl_pkg.sv
// rtl/qeciphy_rx_ctrl_pkg.sv - shared types and error codes for the multi-lane RX controller
package qeciphy_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED,
    ST_WAIT_LOCK,
    ST_READY,
    ST_BACKOFF,
    ST_FAULT
  } lane_state_t;

  typedef logic [3:0] err_code_t;
  typedef logic [3:0] retry_t;

  localparam err_code_t RX_ERR_NONE         = 4'd0;
  localparam err_code_t RX_ERR_CRC          = 4'd1;
  localparam err_code_t RX_ERR_FAW          = 4'd2;
  localparam err_code_t RX_ERR_LOCK_TIMEOUT = 4'd3;
  localparam err_code_t RX_ERR_LOCK_LOSS    = 4'd4;

endpackage

// File: rtl/qeciphy_rx_controller_mc_lane_ctrl.sv
// rtl/qeciphy_rx_controller_mc_lane_ctrl.sv - one lane's sequencer (qeciphy_rx_lane_ctrl): lock wait, retry/backoff, fault
// Retry/backoff only when QECIPHY_RX_AUTO_RETRY_EN is defined; otherwise any error is fatal.
module qeciphy_rx_lane_ctrl
  import qeciphy_rx_ctrl_pkg::*;
#(
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int BACKOFF_CYCLES = 32,
  parameter int MAX_RETRIES    = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  logic      locked,
  input  logic      crc_err,
  input  logic      faw_err,
  output logic      rx_enable,
  output logic      rx_rdy,
  output logic      fault,
  output err_code_t err_code,
  output retry_t    retry_cnt,
  output logic      rdy_next,
  output logic      fatal_next
);

`ifdef QECIPHY_RX_AUTO_RETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  // One timer serves both the lock wait and the backoff hold; they never overlap.
  localparam int TIMER_W = $clog2(LOCK_TIMEOUT > BACKOFF_CYCLES ? LOCK_TIMEOUT : BACKOFF_CYCLES);
  localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BACKOFF_LAST = TIMER_W'(BACKOFF_CYCLES - 1);
  localparam retry_t             RETRY_LIMIT  = retry_t'(MAX_RETRIES);

  lane_state_t        state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  err_code_t          code, code_nxt;
  retry_t             retries, retries_nxt;
  logic               error;
  err_code_t          cause;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    code_nxt    = code;
    retries_nxt = retries;
    error       = 1'b0;
    cause       = RX_ERR_NONE;
    if (!enable) begin
      state_nxt   = ST_DISABLED;
      timer_nxt   = '0;
      code_nxt    = RX_ERR_NONE;
      retries_nxt = '0;
    end else begin
      case (state)
        ST_DISABLED: begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end
        ST_WAIT_LOCK: begin
          if (locked) begin
            state_nxt = ST_READY;
          end else if (timer == LOCK_LAST) begin
            error = 1'b1;
            cause = RX_ERR_LOCK_TIMEOUT;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        ST_READY: begin
          if (crc_err) begin
            error = 1'b1;
            cause = RX_ERR_CRC;
          end else if (faw_err) begin
            error = 1'b1;
            cause = RX_ERR_FAW;
          end else if (!locked) begin
            error = 1'b1;
            cause = RX_ERR_LOCK_LOSS;
          end
        end
        ST_BACKOFF: begin
          if (timer == BACKOFF_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: state_nxt = ST_FAULT;
      endcase
      if (error) begin
        code_nxt  = cause;
        timer_nxt = '0;
        if (AUTO_RETRY && (retries < RETRY_LIMIT)) begin
          state_nxt   = ST_BACKOFF;
          retries_nxt = retries + 1'b1;
        end else begin
          state_nxt = ST_FAULT;
        end
      end
    end
  end

  assign rdy_next   = (state_nxt == ST_READY);
  assign fatal_next = (state_nxt == ST_FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_DISABLED;
      timer     <= '0;
      code      <= RX_ERR_NONE;
      retries   <= '0;
      rx_enable <= 1'b0;
      rx_rdy    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      code      <= code_nxt;
      retries   <= retries_nxt;
      rx_enable <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_READY);
      rx_rdy    <= rdy_next;
      fault     <= fatal_next;
    end
  end

  assign err_code  = code;
  assign retry_cnt = retries;

endmodule

// File: rtl/qeciphy_rx_controller_mc.sv
// rtl/qeciphy_rx_controller_mc.sv - N-lane RX controller with registered ready/fatal aggregates
// Optional feature macro: QECIPHY_RX_AUTO_RETRY_EN (retry with backoff before fault).
module qeciphy_rx_controller_mc
  import qeciphy_rx_ctrl_pkg::*;
#(
  parameter int N_LANES        = 4,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int BACKOFF_CYCLES = 32,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_LANES-1:0]   enable_i,
  input  logic [N_LANES-1:0]   rx_locked_i,
  input  logic [N_LANES-1:0]   crc_err_i,
  input  logic [N_LANES-1:0]   faw_err_i,
  output logic [N_LANES-1:0]   rx_enable_o,
  output logic [N_LANES-1:0]   rx_rdy_o,
  output logic [N_LANES-1:0]   rx_fault_fatal_o,
  output logic [4*N_LANES-1:0] rx_error_code_o,
  output logic [4*N_LANES-1:0] retry_cnt_o,
  output logic                 all_rdy_o,
  output logic                 any_fatal_o
);

  logic [N_LANES-1:0] rdy_nxt;
  logic [N_LANES-1:0] fatal_nxt;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    qeciphy_rx_lane_ctrl #(
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .BACKOFF_CYCLES(BACKOFF_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES)
    ) u_lane (
      .clk       (clk_i),
      .rst       (rst_i),
      .enable    (enable_i[k]),
      .locked    (rx_locked_i[k]),
      .crc_err   (crc_err_i[k]),
      .faw_err   (faw_err_i[k]),
      .rx_enable (rx_enable_o[k]),
      .rx_rdy    (rx_rdy_o[k]),
      .fault     (rx_fault_fatal_o[k]),
      .err_code  (rx_error_code_o[4*k +: 4]),
      .retry_cnt (retry_cnt_o[4*k +: 4]),
      .rdy_next  (rdy_nxt[k]),
      .fatal_next(fatal_nxt[k])
    );
  end

  // Built from next-state lane values so the aggregates land on the same cycle as the lane outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      all_rdy_o   <= 1'b0;
      any_fatal_o <= 1'b0;
    end else begin
      all_rdy_o   <= &rdy_nxt;
      any_fatal_o <= |fatal_nxt;
    end
  end

endmodule

// File: tb/tb_qeciphy_rx_controller_mc.sv
// tb/tb_qeciphy_rx_controller_mc.sv - self-checking bench for qeciphy_rx_controller_mc
module tb_qeciphy_rx_controller_mc;
  localparam int N  = 4;
  localparam int LT = 128;
  localparam int BC = 4;
  localparam int MR = 2;
`ifdef QECIPHY_RX_AUTO_RETRY_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int M_OFF = 0, M_WAIT = 1, M_READY = 2, M_BACK = 3, M_FAULT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] en = '0, locked = '0, crc = '0, faw = '0;
  logic [N-1:0] rx_en, rdy, fatal;
  logic [4*N-1:0] code, retry;
  logic all_rdy, any_fatal;
  logic [45:0] dut_vec;

  int m_mode[N], m_cnt[N], m_code[N], m_retry[N];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qeciphy_rx_controller_mc #(
    .N_LANES(N), .LOCK_TIMEOUT(LT), .BACKOFF_CYCLES(BC), .MAX_RETRIES(MR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .rx_locked_i(locked),
    .crc_err_i(crc), .faw_err_i(faw), .rx_enable_o(rx_en), .rx_rdy_o(rdy),
    .rx_fault_fatal_o(fatal), .rx_error_code_o(code), .retry_cnt_o(retry),
    .all_rdy_o(all_rdy), .any_fatal_o(any_fatal)
  );

  assign dut_vec = {all_rdy, any_fatal, fatal, rdy, rx_en, code, retry};

  function automatic void model_error(int l, int c);
    m_code[l] = c;
    m_cnt[l]  = 0;
    if (AUTO && m_retry[l] < MR) begin
      m_retry[l]++;
      m_mode[l] = M_BACK;
    end else begin
      m_mode[l] = M_FAULT;
    end
  endfunction

  function automatic void model_step();
    for (int l = 0; l < N; l++) begin
      if (rst || !en[l]) begin
        m_mode[l] = M_OFF; m_cnt[l] = 0; m_code[l] = 0; m_retry[l] = 0;
      end else if (m_mode[l] == M_OFF) begin
        m_mode[l] = M_WAIT; m_cnt[l] = 0;
      end else if (m_mode[l] == M_WAIT) begin
        if (locked[l]) m_mode[l] = M_READY;
        else if (m_cnt[l] == LT - 1) model_error(l, 3);
        else m_cnt[l]++;
      end else if (m_mode[l] == M_READY) begin
        if (crc[l]) model_error(l, 1);
        else if (faw[l]) model_error(l, 2);
        else if (!locked[l]) model_error(l, 4);
      end else if (m_mode[l] == M_BACK) begin
        m_cnt[l]++;
        if (m_cnt[l] == BC) begin m_mode[l] = M_WAIT; m_cnt[l] = 0; end
      end
    end
  endfunction

  function automatic logic [45:0] expected();
    logic [N-1:0] e, r, f;
    logic [4*N-1:0] c, t;
    logic ar, af;
    ar = 1'b1; af = 1'b0;
    for (int l = 0; l < N; l++) begin
      e[l] = (m_mode[l] == M_WAIT) || (m_mode[l] == M_READY);
      r[l] = (m_mode[l] == M_READY);
      f[l] = (m_mode[l] == M_FAULT);
      c[4*l +: 4] = 4'(m_code[l]);
      t[4*l +: 4] = 4'(m_retry[l]);
      ar &= r[l];
      af |= f[l];
    end
    return {ar, af, f, r, e, c, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; locked = '0; crc = '0; faw = '0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (dut_vec !== 46'd0) begin
      errors++; $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    rst = 1'b0;
  endtask

  task automatic test_lane0_lock();
    for (int c = 0; c < 120; c++) begin
      en[0] = (c >= 10); locked[0] = (c >= 115);
      tick();
      checks++;
      if (dut_vec !== expected()) begin
        errors++; $display("FAIL lane0_seq c=%0d: got %h want %h", c, dut_vec, expected());
      end
      if (c == 10) begin
        checks++;
        if (rx_en[0] !== 1'b1) begin errors++; $display("FAIL lane0_enable: got %b want 1", rx_en[0]); end
      end
    end
    checks++;
    if ({rdy[0], all_rdy, rx_en[3:1]} !== 5'b10000) begin
      errors++; $display("FAIL lane0_ready: got %b want 10000", {rdy[0], all_rdy, rx_en[3:1]});
    end
  endtask

  task automatic test_crc_faw_retry();
    en[1] = 1'b1; locked[1] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (rdy[1] !== 1'b1) begin errors++; $display("FAIL lane1_ready: got %b want 1", rdy[1]); end
    crc[1] = 1'b1; faw[1] = 1'b1;
    tick();
    crc[1] = 1'b0; faw[1] = 1'b0;
    checks++;
    if ({code[7:4], rx_en[1], retry[7:4], fatal[1]} !== {4'd1, 1'b0, 4'(AUTO), !AUTO}) begin
      errors++; $display("FAIL lane1_crc_wins: got %h want %h",
        {code[7:4], rx_en[1], retry[7:4], fatal[1]}, {4'd1, 1'b0, 4'(AUTO), !AUTO});
    end
    for (int i = 1; i <= BC; i++) begin
      tick();
      checks++;
      if (dut_vec !== expected()) begin
        errors++; $display("FAIL lane1_backoff i=%0d: got %h want %h", i, dut_vec, expected());
      end
      checks++;
      if (rx_en[1] !== ((i == BC) ? AUTO : 1'b0)) begin
        errors++; $display("FAIL lane1_reenable i=%0d: got %b want %b", i, rx_en[1], (i == BC) ? AUTO : 1'b0);
      end
    end
  endtask

  task automatic test_lock_timeout();
    en[2] = 1'b1; en[3] = 1'b1; locked[2] = 1'b0; locked[3] = 1'b0;
    for (int c = 1; c <= 450; c++) begin
      tick();
      checks++;
      if (dut_vec !== expected()) begin
        errors++; $display("FAIL timeout_seq c=%0d: got %h want %h", c, dut_vec, expected());
      end
      if (c == 128 || c == 129) begin
        checks++;
        if (code[11:8] !== ((c == 129) ? 4'd3 : 4'd0)) begin
          errors++; $display("FAIL lane2_timeout_code c=%0d: got %0d want %0d", c, code[11:8], (c == 129) ? 3 : 0);
        end
      end
    end
    checks++;
    if ({fatal[2], retry[11:8], code[11:8], any_fatal} !== {1'b1, (AUTO ? 4'd2 : 4'd0), 4'd3, 1'b1}) begin
      errors++; $display("FAIL lane2_fatal: got %h want %h",
        {fatal[2], retry[11:8], code[11:8], any_fatal}, {1'b1, (AUTO ? 4'd2 : 4'd0), 4'd3, 1'b1});
    end
  endtask

  task automatic test_fault_reenable();
    en[3] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({fatal[3], rx_en[3], code[15:12], retry[15:12]} !== 11'd0) begin
        errors++; $display("FAIL lane3_cleared i=%0d: got %h want 0", i, {fatal[3], rx_en[3], code[15:12], retry[15:12]});
      end
    end
    en[3] = 1'b1;
    tick();
    checks++;
    if ({rx_en[3], fatal[3], code[15:12]} !== 6'b100000) begin
      errors++; $display("FAIL lane3_restart: got %b want 100000", {rx_en[3], fatal[3], code[15:12]});
    end
  endtask

  task automatic test_reset_midop();
    en = '0; tick();
    en = '1; locked = '1; crc = '0; faw = '0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({all_rdy, rdy} !== 5'b11111) begin errors++; $display("FAIL all_ready: got %b want 11111", {all_rdy, rdy}); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (dut_vec !== 46'd0) begin errors++; $display("FAIL reset_midop: got %h want 0", dut_vec); end
  endtask

  task automatic test_faw_ready();
    for (int i = 0; i < 3; i++) tick();
    faw[0] = 1'b1;
    tick();
    faw[0] = 1'b0;
    checks++;
    if ({rdy[0], rx_en[0], fatal[0], code[3:0], retry[3:0]} !== {2'b00, !AUTO, 4'd2, 4'(AUTO)}) begin
      errors++; $display("FAIL lane0_faw: got %h want %h",
        {rdy[0], rx_en[0], fatal[0], code[3:0], retry[3:0]}, {2'b00, !AUTO, 4'd2, 4'(AUTO)});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(999) == 0);
      for (int l = 0; l < N; l++) begin
        if ($urandom_range(299) == 0) en[l] = ~en[l];
        if ($urandom_range(59) == 0) locked[l] = ~locked[l];
        crc[l] = ($urandom_range(79) == 0);
        faw[l] = ($urandom_range(79) == 0);
      end
      tick();
      checks++;
      if (dut_vec !== expected()) begin
        errors++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec, expected());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lane0_lock();
    test_crc_faw_retry();
    test_lock_timeout();
    test_fault_reenable();
    test_reset_midop();
    test_faw_ready();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qeciphy_rx_controller_mc.md
Name: qeciphy_rx_controller_mc

Overview:
Multi-lane successor to the single-lane RX controller. It runs N_LANES independent lane sequencers, one per channel. Each sequencer enables the receive boundary generator, waits for lock with a timeout, and reports readiness. On CRC, FAW, lock-loss or lock-timeout errors it retries with a backoff period, up to a bounded count, before declaring a fatal fault. Aggregate ready and fault outputs feed the link-level controller.

Parameters:
N_LANES, 4, number of independent RX lanes.
LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before a timeout error (>=128).
BACKOFF_CYCLES, 32, cycles rx_enable_o is held low between retries (>=2).
MAX_RETRIES, 3, retries allowed before FAULT (0..15).

Ports:
clk_i  in  1  single clock.
rst_i  in  1  synchronous, active-high reset.
enable_i  in  N_LANES  per-lane enable request.
rx_locked_i  in  N_LANES  per-lane word-boundary lock.
crc_err_i  in  N_LANES  per-lane CRC error, sticky while rx_enable_o is high.
faw_err_i  in  N_LANES  per-lane frame-alignment-word error, sticky while rx_enable_o is high.
rx_enable_o  out  N_LANES  per-lane enable to the boundary generator.
rx_rdy_o  out  N_LANES  lane locked and error-free.
rx_fault_fatal_o  out  N_LANES  lane has exhausted its retries.
rx_error_code_o  out  4*N_LANES  last error cause per lane; lane k occupies bits [4k+3:4k].
retry_cnt_o  out  4*N_LANES  retries consumed per lane.
all_rdy_o  out  1  AND of all rx_rdy_o bits.
any_fatal_o  out  1  OR of all rx_fault_fatal_o bits.

Behaviour:
- All outputs are registered. While rst_i=1 at a clock edge, every output is 0 and every lane goes to DISABLED.
- Per-lane states: DISABLED, WAIT_LOCK, READY, BACKOFF, FAULT.
- Error codes: 0 NONE, 1 CRC, 2 FAW, 3 LOCK_TIMEOUT, 4 LOCK_LOSS. Values 5..15 are reserved.
- enable_i low in any state: DISABLED on the next cycle. rx_enable_o, rx_rdy_o and fault are cleared; error code and retry count are cleared. enable_i low has priority over every other event.
- DISABLED with enable_i=1 sampled at cycle t: WAIT_LOCK, and rx_enable_o=1 from t+1.
- WAIT_LOCK:
  - A lock timer counts cycles from 0.
  - rx_locked_i=1 sampled: READY next cycle, rx_rdy_o=1.
  - Timer reaches LOCK_TIMEOUT-1 without lock: error with code 3.
- READY:
  - crc_err_i=1 gives code 1; faw_err_i=1 gives code 2. CRC wins if both are high.
  - Otherwise rx_locked_i=0 gives code 4.
- Error handling, at the cycle after detection:
  - rx_rdy_o=0 and rx_enable_o=0; error code is latched.
  - If retry_cnt < MAX_RETRIES: go to BACKOFF and increment retry_cnt in the same cycle.
  - Else: go to FAULT with rx_fault_fatal_o=1.
- BACKOFF: rx_enable_o stays low for exactly BACKOFF_CYCLES cycles, then WAIT_LOCK with the timer cleared.
- FAULT: absorbing. rx_enable_o=0; leaves only on enable_i low or reset.
- Error code persists through a successful re-lock. It is cleared only by DISABLED or reset. retry_cnt saturates at MAX_RETRIES.
- Error inputs are ignored outside READY. Lanes are fully independent; no cross-lane coupling except all_rdy_o and any_fatal_o, which are registered from the next-state per-lane values so that they align with rx_rdy_o and rx_fault_fatal_o.
- Reset mid-operation: identical to the power-on reset; no partial state survives.

Optional Feature:
QECIPHY_RX_AUTO_RETRY_EN
- Defined: retry/backoff behaviour as specified above.
- Undefined: MAX_RETRIES is ignored, and any error goes directly to FAULT on the next cycle. The BACKOFF state and timer are removed. retry_cnt_o is tied to 0. Lock timeout remains active.

Decomposition:
- Package qeciphy_rx_ctrl_pkg holds:
  - the lane state enum;
  - the 4-bit error-code typedef and constants (RX_ERR_NONE, RX_ERR_CRC, RX_ERR_FAW, RX_ERR_LOCK_TIMEOUT, RX_ERR_LOCK_LOSS);
  - the retry-count typedef.
- Sub-module qeciphy_rx_lane_ctrl holds one lane's FSM, lock timer, backoff timer and retry counter. The top module instantiates N_LANES copies via generate and builds the aggregates.

Test Plan:
Use LOCK_TIMEOUT=128, BACKOFF_CYCLES=4, MAX_RETRIES=2, N_LANES=4.
- Lane 0 enable_i rises at cycle 10, rx_locked_i rises at 115 → rx_enable_o[0]=1 at 11, rx_rdy_o[0]=1 at 116, all other lanes idle, all_rdy_o=0.
- Lane 1 locked, then crc_err_i and faw_err_i assert together → next cycle code=1, rx_enable_o=0, retry_cnt=1; rx_enable_o returns high exactly 4 cycles later.
- Lane 2 never locks → code=3 at cycle 128 after enable. After the 3rd timeout, rx_fault_fatal_o[2]=1, retry_cnt=2, any_fatal_o=1 on the same cycle.
- Lane 3 in FAULT, enable_i low for 16 cycles, then high → outputs cleared next cycle, WAIT_LOCK restarts, code=0.
- All lanes READY, then rst_i pulsed for 1 cycle → all outputs 0 next cycle, all_rdy_o=0.
- Build without QECIPHY_RX_AUTO_RETRY_EN, lane 0 READY then faw_err_i=1 → FAULT next cycle, code=2, retry_cnt_o=0.
